// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single external memory port: core (port 0) has priority,
// loader (port 1) is protected from starvation; each access is a registered, timed-out transaction.
module mem_port_arbiter #(
  parameter int TIMEOUT      = 15,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [3:0]  size0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [3:0]  size1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_size,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] LP_TMAX = 8'(TIMEOUT - 1);
  localparam logic [7:0] LP_SLIM = 8'(STARVE_LIMIT);

  state_t      r_state;
  logic        r_owner;
  logic        r_we;
  logic [7:0]  r_tcnt;
  logic [7:0]  r_starve;

  logic        w_any_req;
  logic        w_pick1;
  logic        w_we;
  logic [3:0]  w_size;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;

  // Port 1 wins only when alone or once the core has used up its consecutive-grant allowance.
  assign w_any_req   = req0 | req1;
  assign w_pick1     = req1 && (!req0 || (r_starve == LP_SLIM));
  assign w_we        = w_pick1 ? we1    : we0;
  assign w_size      = w_pick1 ? size1  : size0;
  assign w_addr      = w_pick1 ? addr1  : addr0;
  assign w_wdata     = w_pick1 ? wdata1 : wdata0;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_we      <= 1'b0;
      r_tcnt    <= 8'd0;
      r_starve  <= 8'd0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata     <= 32'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_size  <= 4'd0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner   <= w_pick1;
            r_we      <= w_we;
            mem_addr  <= w_addr;
            mem_wdata <= w_wdata;
            mem_size  <= w_size;
            mem_read  <= !w_we;
            mem_write <= w_we;
            r_tcnt    <= 8'd0;
            if (!w_pick1 && req1) begin
              if (r_starve != LP_SLIM) r_starve <= r_starve + 8'd1;
            end else begin
              r_starve <= 8'd0;
            end
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Ready is checked before the timeout so a late completion still succeeds.
          if (mem_ready) begin
            if (!r_we) rdata <= mem_rdata;
            ack0      <= !r_owner;
            ack1      <= r_owner;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            r_state   <= S_DONE;
          end else if (r_tcnt == LP_TMAX) begin
            err0      <= !r_owner;
            err1      <= r_owner;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts winner, outcome,
// completion cycle and rdata; a memory responder and a completion monitor check the DUT.
module tb_mem_port_arbiter;

  localparam int TIMEOUT      = 15;
  localparam int STARVE_LIMIT = 4;
  // Expected port order (bit i = port of i-th ack) for two always-requesting ports: 0,0,0,0,1,0,0,0,0,1.
  localparam logic [9:0] EXP_ORDER = 10'b10_0001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [3:0]  size0, size1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_size;
  logic        mem_read, mem_write, mem_ready;
  logic [1:0]  o_dbg_state;

  typedef struct {
    int          d;
    logic [31:0] rd;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  size;
  } plan_t;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fails = 0;
  logic [65:0] exp_q[$];
  plan_t       plan_q[$];
  int          force_d_q[$];
  logic [31:0] force_rd_q[$];
  int          m_next_free = 0;
  int          m_starve = 0;
  logic [31:0] m_rdata = 32'd0;
  int          last_busy_len = 0;
  int          ack_log[$];

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .size0(size0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .size1(size1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] rand_size();
    case ($urandom_range(0, 4))
      0:       return 4'b0000;
      1:       return 4'b0001;
      2:       return 4'b0010;
      3:       return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  // Memory wait states: mostly short, with boundary and never-ready cases mixed in.
  function automatic int rand_delay();
    int r;
    r = $urandom_range(0, 19);
    if (r < 12) return r % 4;
    if (r < 15) return TIMEOUT - 1;
    if (r < 17) return TIMEOUT + 3;
    return $urandom_range(0, TIMEOUT - 1);
  endfunction

  // ---------------- reference model ----------------
  // Grants happen on the first edge the arbiter is free and someone requests; a transaction
  // with d wait states occupies k = min(d+1, TIMEOUT) busy cycles plus one completion cycle.
  always @(posedge clk) begin : model_blk
    int    p;
    int    k;
    bit    e;
    plan_t pl;
    cyc++;
    if (reset) begin
      m_next_free = cyc + 1;
      m_starve    = 0;
      m_rdata     = 32'd0;
      exp_q.delete();
      plan_q.delete();
    end else if (cyc >= m_next_free && (req0 || req1)) begin
      p = (req1 && (!req0 || m_starve == STARVE_LIMIT)) ? 1 : 0;
      if (p == 0 && req1) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
      else                m_starve = 0;
      pl.we    = p ? we1 : we0;
      pl.addr  = p ? addr1 : addr0;
      pl.wdata = p ? wdata1 : wdata0;
      pl.size  = p ? size1 : size0;
      pl.d     = (force_d_q.size() != 0) ? force_d_q.pop_front() : rand_delay();
      pl.rd    = (force_rd_q.size() != 0) ? force_rd_q.pop_front() : $urandom();
      e = (pl.d >= TIMEOUT);
      k = e ? TIMEOUT : pl.d + 1;
      if (!e && !pl.we) m_rdata = pl.rd;
      plan_q.push_back(pl);
      exp_q.push_back({p[0], e, 32'(cyc + k), m_rdata});
      m_next_free = cyc + k + 2;
    end
  end

  // ---------------- memory responder ----------------
  initial begin : responder
    bit    in_txn;
    int    bcnt;
    plan_t cur;
    in_txn = 0;
    bcnt = 0;
    cur = '{d: 0, rd: 32'd0, we: 1'b0, addr: 32'd0, wdata: 32'd0, size: 4'd0};
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_read || mem_write) begin
        if (!in_txn) begin
          if (plan_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL unplanned_access: mem_addr %0h with no granted request", mem_addr);
          end else begin
            cur = plan_q.pop_front();
          end
          in_txn = 1;
          bcnt = 0;
        end
        check("mem_port", {mem_read, mem_write, mem_addr, mem_wdata, mem_size},
              {!cur.we, cur.we, cur.addr, cur.wdata, cur.size});
        mem_ready = (bcnt == cur.d);
        mem_rdata = mem_ready ? cur.rd : $urandom();
        bcnt++;
      end else begin
        if (in_txn) last_busy_len = bcnt;
        in_txn = 0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom();
      end
    end
  end

  // ---------------- completion monitor / scoreboard ----------------
  initial begin : monitor
    logic [65:0] e;
    forever begin
      @(negedge clk);
      if (ack0 || ack1 || err0 || err1) begin
        check("pulse_onehot", 128'($onehot({ack0, ack1, err0, err1})), 128'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_pulse: ack0=%0b ack1=%0b err0=%0b err1=%0b at cycle %0d",
                   ack0, ack1, err0, err1, cyc);
        end else begin
          e = exp_q.pop_front();
          check("completion{port,err,cycle,rdata}", {(ack1 | err1), (err0 | err1), 32'(cyc), rdata}, e);
          if (ack0 || ack1) ack_log.push_back(ack1 ? 1 : 0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int p, input logic we, input logic [3:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      req0 = 1'b1; we0 = we; size0 = sz; addr0 = a; wdata0 = wd;
    end else begin
      req1 = 1'b1; we1 = we; size1 = sz; addr1 = a; wdata1 = wd;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) begin
      req0 = 1'b0; we0 = 1'($urandom()); size0 = 4'($urandom()); addr0 = $urandom(); wdata0 = $urandom();
    end else begin
      req1 = 1'b0; we1 = 1'($urandom()); size1 = 4'($urandom()); addr1 = $urandom(); wdata1 = $urandom();
    end
  endtask

  task automatic issue_rand(input int p);
    issue(p, 1'($urandom_range(0, 1)), rand_size(), $urandom(), $urandom());
  endtask

  // Waits for the port's ack/err, then releases req right after the completion cycle.
  task automatic wait_done(input int p, output int lat, output bit was_err);
    int start;
    bit got;
    start = cyc;
    got = 0;
    was_err = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got     = (p == 0) ? (ack0 | err0) : (ack1 | err1);
      was_err = (p == 0) ? err0 : err1;
    end
    n_checks++;
    if (!got) begin
      n_fails++;
      $display("FAIL wait_done_p%0d: no ack/err within 300 cycles", p);
    end
    lat = cyc - start;
    @(posedge clk);
    #1;
    drop(p);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int          lat;
    bit          was_err;
    bit          seen;
    logic [31:0] hold;
    logic [9:0]  got_order;

    reset = 1'b1;
    drop(0);
    drop(1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_state", {mem_read, mem_write, ack0, ack1, err0, err1, mem_addr, mem_wdata,
                          mem_size, rdata, o_dbg_state}, 128'd0);

    // Single core read, memory ready at once.
    force_d_q.push_back(0);
    force_rd_q.push_back(32'hDEAD_BEEF);
    @(posedge clk); #1;
    issue(0, 1'b0, 4'b0000, 32'h0000_0100, $urandom());
    wait_done(0, lat, was_err);
    check("t1_latency", lat, 2);
    @(negedge clk);
    check("t1_busy_len", last_busy_len, 1);
    check("t1_rdata", rdata, 32'hDEAD_BEEF);

    // Both ports request continuously: starvation protection order.
    ack_log.delete();
    repeat (10) force_d_q.push_back(0);
    @(posedge clk); #1;
    fork
      begin
        int l; bit er;
        for (int i = 0; i < 8; i++) begin
          issue_rand(0);
          wait_done(0, l, er);
        end
      end
      begin
        int l; bit er;
        for (int i = 0; i < 2; i++) begin
          issue_rand(1);
          wait_done(1, l, er);
        end
      end
    join
    check("t2_ack_count", ack_log.size(), 10);
    got_order = '0;
    for (int i = 0; i < 10 && i < ack_log.size(); i++) got_order[i] = ack_log[i][0];
    check("t2_grant_order", got_order, EXP_ORDER);

    // Loader write with three wait states; rdata must not change.
    hold = m_rdata;
    force_d_q.push_back(3);
    issue(1, 1'b1, 4'b0001, 32'h0000_0040, 32'h1234_5678);
    wait_done(1, lat, was_err);
    check("t3_latency", lat, 5);
    @(negedge clk);
    check("t3_busy_len", last_busy_len, 4);
    check("t3_rdata_kept", rdata, hold);

    // Memory never ready -> abort; ready on the last allowed cycle -> success.
    force_d_q.push_back(TIMEOUT + 10);
    @(posedge clk); #1;
    issue(0, 1'b0, rand_size(), $urandom(), $urandom());
    wait_done(0, lat, was_err);
    check("t4_timeout_err", was_err, 1);
    check("t4_timeout_latency", lat, TIMEOUT + 1);
    @(negedge clk);
    check("t4_timeout_busy_len", last_busy_len, TIMEOUT);
    check("t4_idle_after_err", o_dbg_state, 2'd0);
    force_d_q.push_back(TIMEOUT - 1);
    @(posedge clk); #1;
    issue(0, 1'b0, rand_size(), $urandom(), $urandom());
    wait_done(0, lat, was_err);
    check("t4_late_ready_ok", was_err, 0);
    @(negedge clk);
    check("t4_late_ready_busy_len", last_busy_len, TIMEOUT);

    // Reset during the second busy cycle.
    force_d_q.push_back(50);
    @(posedge clk); #1;
    issue(0, 1'b0, rand_size(), $urandom(), $urandom());
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = mem_read;
    end
    check("t5_busy_seen", seen, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    drop(0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t5_after_reset", {mem_read, mem_write, ack0, ack1, err0, err1, mem_addr, mem_wdata,
                             mem_size, rdata, o_dbg_state}, 128'd0);
    repeat (4) @(negedge clk);
    force_d_q.push_back(0);
    @(posedge clk); #1;
    issue(0, 1'b0, rand_size(), $urandom(), $urandom());
    wait_done(0, lat, was_err);
    check("t5_post_reset_latency", lat, 2);

    // req0 dropped while busy; req1 raised during the completion cycle is not granted there.
    force_d_q.push_back(2);
    force_d_q.push_back(0);
    @(posedge clk); #1;
    issue(0, 1'b0, rand_size(), $urandom(), $urandom());
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = mem_read;
    end
    @(posedge clk); #1;
    drop(0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = ack0;
    end
    check("t6_ack0_after_drop", seen, 1);
    issue_rand(1);
    wait_done(1, lat, was_err);
    check("t6_no_grant_in_done", lat, 3);

    // Random traffic on both ports.
    @(posedge clk); #1;
    fork
      begin
        int l; bit er;
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          issue_rand(0);
          wait_done(0, l, er);
        end
      end
      begin
        int l; bit er;
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          issue_rand(1);
          wait_done(1, l, er);
        end
      end
    join

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("plan_q_drained", plan_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
